// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences one weight-load job from the weight stream into the weight buffer and on to the PE array.
// Ports: clk/nrst (async active-low); start + cfg_num_elems launch a job;
//   s_tdata/s_tvalid/s_tlast/s_tready: 32-bit weight stream, two elements per word;
//   wb_weight_en/wb_data: buffer write; wb_out_en/wb_out_vld/wb_data_out: buffer drain;
//   pe_wvalid/pe_wdata/pe_wlast: elements to the PE array; busy/done/err: job status.
module weight_load_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CAP_ELEMS = 14,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  input  logic [CNT_W-1:0] cfg_num_elems,
  input  logic [31:0] s_tdata,
  input  logic s_tvalid,
  input  logic s_tlast,
  output logic s_tready,
  output logic wb_weight_en,
  output logic [31:0] wb_data,
  output logic wb_out_en,
  input  logic wb_out_vld,
  input  logic [DATA_WIDTH-1:0] wb_data_out,
  output logic pe_wvalid,
  output logic [DATA_WIDTH-1:0] pe_wdata,
  output logic pe_wlast,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int OCC_W = $clog2(CAP_ELEMS + 3);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] total, words_total, words_rx, elems_tx;
  logic [CNT_W:0] drain_last_idx;
  logic [OCC_W-1:0] occ, occ_add, occ_sub, occ_next;
  logic last_beat, last_drain, start_ok;
  always_comb begin
    // one slot of margin below CAP-2 absorbs the cycle before a written word starts draining
    s_tready = (state == S_LOAD) && (words_rx < words_total) && (occ <= OCC_W'(CAP_ELEMS - 3));
    wb_weight_en = s_tvalid & s_tready;
    wb_data = s_tdata;
    pe_wdata = wb_data_out;
    wb_out_en = busy;
    pe_wvalid = wb_out_vld && (elems_tx < total);
    pe_wlast = pe_wvalid && (elems_tx == total - CNT_W'(1));
    last_beat = (words_rx + CNT_W'(1)) == words_total;
    // the pad element of an odd job is still drained, so drain ends at 2*words_total-1
    drain_last_idx = {words_total, 1'b0} - (CNT_W + 1)'(1);
    last_drain = {1'b0, elems_tx} == drain_last_idx;
    occ_add = occ + (wb_weight_en ? OCC_W'(2) : OCC_W'(0));
    occ_sub = (wb_out_vld && occ_add != '0) ? occ_add - OCC_W'(1) : occ_add;
    occ_next = (occ_sub > OCC_W'(CAP_ELEMS)) ? OCC_W'(CAP_ELEMS) : occ_sub;
    // a start landing on the done pulse of a zero-length job is dropped
    start_ok = start && (state == S_IDLE) && !done;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      total <= '0;
      words_total <= '0;
      words_rx <= '0;
      elems_tx <= '0;
      occ <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      occ <= occ_next;
      if (busy && wb_out_vld && elems_tx != '1) elems_tx <= elems_tx + CNT_W'(1);
      if (wb_weight_en) begin
        if (words_rx != '1) words_rx <= words_rx + CNT_W'(1);
        if (s_tlast != last_beat) err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_ok && cfg_num_elems != '0) begin
            total <= cfg_num_elems;
            words_total <= (cfg_num_elems >> 1) + CNT_W'(cfg_num_elems[0]);
            words_rx <= '0;
            elems_tx <= '0;
            occ <= '0;
            err <= 1'b0;
            busy <= 1'b1;
            state <= S_LOAD;
          end else if (start_ok) begin
            done <= 1'b1;
          end
        end
        S_LOAD: if (wb_weight_en && last_beat) state <= S_DRAIN;
        S_DRAIN: begin
          if (wb_out_vld && last_drain) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: table-driven and randomized jobs against a queue model of the weight buffer.
module tb_weight_load_ctrl;
  localparam int CAP = 14;
  typedef struct {
    int n;
    int tl;
    bit rnd;
    bit hold;
    int abort;
    bit exp_err;
  } vec_t;
  logic clk = 0;
  logic nrst = 0;
  logic start = 0;
  logic [15:0] cfg = '0;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 0;
  logic s_tlast = 0;
  logic s_tready, wb_weight_en, wb_out_en, pe_wvalid, pe_wlast, busy, done, err;
  logic [31:0] wb_data;
  logic wb_out_vld = 0;
  logic [15:0] wb_data_out = '0;
  logic [15:0] pe_wdata;
  logic [15:0] buf_q[$];
  logic [15:0] exp_pe[$];
  logic [31:0] wd[64];
  int n_cmp = 0, n_fail = 0;
  int done_cnt = 0, pe_cnt = 0, drained = 0;
  bit stall = 0, rnd_sink = 0;
  vec_t tbl[9];
  weight_load_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .cfg_num_elems(cfg),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .wb_weight_en(wb_weight_en), .wb_data(wb_data), .wb_out_en(wb_out_en),
    .wb_out_vld(wb_out_vld), .wb_data_out(wb_data_out),
    .pe_wvalid(pe_wvalid), .pe_wdata(pe_wdata), .pe_wlast(pe_wlast),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // weight buffer: a written word yields its first element on the next cycle
  always @(posedge clk) begin
    if (!nrst) buf_q.delete();
    else begin
      if (wb_out_vld && buf_q.size() > 0) begin
        void'(buf_q.pop_front());
        drained++;
      end
      if (wb_weight_en) begin
        buf_q.push_back(wb_data[15:0]);
        buf_q.push_back(wb_data[31:16]);
      end
    end
    #1;
    wb_out_vld = buf_q.size() > 0 && wb_out_en && !stall && (!rnd_sink || $urandom_range(0, 1) == 1);
    wb_data_out = buf_q.size() > 0 ? buf_q[0] : '0;
  end
  always @(negedge clk) begin
    if (nrst) begin
      check("occ_max", 64'(buf_q.size() <= CAP), 1);
      check("wlast_qual", pe_wlast & ~pe_wvalid, 0);
      if (pe_wvalid) begin
        check("pe_pending", 64'(exp_pe.size() > 0), 1);
        if (exp_pe.size() > 0) begin
          check("pe_data", pe_wdata, exp_pe[0]);
          check("pe_last", pe_wlast, exp_pe.size() == 1);
          void'(exp_pe.pop_front());
        end
        pe_cnt++;
      end
      if (done) done_cnt++;
    end
  end
  task automatic run_job(input vec_t v);
    int words, beat, cyc, lowcnt, d0, p0, dr0;
    bit acc, first;
    words = (v.n + 1) / 2;
    beat = 0;
    cyc = 0;
    lowcnt = 0;
    first = 1;
    d0 = done_cnt;
    p0 = pe_cnt;
    dr0 = drained;
    exp_pe.delete();
    for (int i = 0; i < words; i++) begin
      wd[i] = $urandom;
      exp_pe.push_back(wd[i][15:0]);
      if (2 * i + 1 < v.n) exp_pe.push_back(wd[i][31:16]);
    end
    stall = v.hold;
    @(posedge clk);
    #1 start = 1;
    cfg = 16'(v.n);
    @(posedge clk);
    #1 start = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      s_tvalid = beat < words && (!v.rnd || $urandom_range(0, 1) == 1);
      s_tdata = wd[beat];
      s_tlast = (beat + 1) == v.tl;
      @(negedge clk);
      if (first) begin
        check("busy_start", busy, 1);
        check("tready_start", s_tready, 1);
        check("err_clear", err, 0);
        first = 0;
      end
      if (v.abort != 0 && cyc == v.abort) begin
        #2 nrst = 0;
        #1 check("reset_outs", {s_tready, wb_weight_en, wb_out_en, pe_wvalid, pe_wlast, busy, done, err}, 0);
        @(posedge clk);
        #1 nrst = 1;
        s_tvalid = 0;
        s_tlast = 0;
        exp_pe.delete();
        stall = 0;
        return;
      end
      if (stall) begin
        check("tready_occ", s_tready, buf_q.size() <= CAP - 3);
        if (buf_q.size() >= 12) lowcnt++;
        if (lowcnt == 4) begin
          check("stall_occ", buf_q.size(), 12);
          check("stall_beats", beat, 6);
          stall = 0;
        end
      end
      acc = wb_weight_en;
      @(posedge clk);
      if (acc) beat++;
      #1 cyc++;
    end
    s_tvalid = 0;
    s_tlast = 0;
    check("job_timeout", 64'(cyc < 3000), 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("pe_count", pe_cnt - p0, v.n);
    check("drained", drained - dr0, 2 * words);
    check("err", err, v.exp_err);
    check("busy_end", busy, 0);
  endtask
  initial begin
    vec_t v;
    int w;
    tbl = '{'{6, 3, 0, 0, 0, 0}, '{5, 3, 0, 0, 0, 0}, '{40, 20, 0, 1, 0, 0},
            '{4, 1, 0, 0, 0, 1}, '{4, 2, 0, 0, 0, 0}, '{10, 5, 0, 0, 3, 0},
            '{2, 1, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 1}, '{1, 1, 1, 0, 0, 0}};
    repeat (2) @(posedge clk);
    #1 check("reset_state", {s_tready, wb_weight_en, wb_out_en, pe_wvalid, pe_wlast, busy, done, err}, 0);
    nrst = 1;
    @(posedge clk);
    #1 start = 1;
    cfg = 0;
    s_tvalid = 1;
    s_tlast = 1;
    @(posedge clk);
    #1 cfg = 6;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_tready", s_tready, 0);
    check("stray_write", wb_weight_en, 0);
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("start_on_done", busy, 0);
    check("stray_err", err, 0);
    s_tvalid = 0;
    s_tlast = 0;
    foreach (tbl[i]) run_job(tbl[i]);
    rnd_sink = 1;
    for (int k = 0; k < 20; k++) begin
      v.n = $urandom_range(1, 30);
      w = (v.n + 1) / 2;
      v.tl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : w;
      v.rnd = 1;
      v.hold = 0;
      v.abort = 0;
      v.exp_err = v.tl != w;
      run_job(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequences one weight-load job from the AXI-Stream weight port into the 16-bit weight buffer and presents the drained elements to the PE array. It:
- counts 32-bit words (two 16-bit elements each) against the configured job size;
- throttles the stream with an element-occupancy credit so the 14-element buffer never overruns;
- drives the buffer's write and output enables;
- flags the final element, suppresses the pad element of odd-length jobs, and reports framing errors.

## Interface
Parameters:
- DATA_WIDTH, 16, element width; one stream word carries exactly 2 elements.
- CAP_ELEMS, 14, weight-buffer capacity in elements.
- CNT_W, 16, width of the element counters.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- cfg_num_elems  in  CNT_W  total elements in the job; sampled on an accepted start.
- s_tdata  in  32  stream word; element 0 is in [15:0], element 1 in [31:16].
- s_tvalid  in  1  stream valid.
- s_tlast  in  1  stream last-word marker.
- s_tready  out  1  stream ready.
- wb_weight_en  out  1  buffer write strobe; equals s_tvalid & s_tready.
- wb_data  out  32  buffer write data; equals s_tdata combinationally.
- wb_out_en  out  1  buffer output enable.
- wb_out_vld  in  1  buffer output-valid, one element per cycle.
- wb_data_out  in  DATA_WIDTH  buffer output element.
- pe_wvalid  out  1  element valid to the PE array.
- pe_wdata  out  DATA_WIDTH  element to the PE array; equals wb_data_out.
- pe_wlast  out  1  marks the final real element; qualified by pe_wvalid.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky framing error; cleared by the next accepted start.

## Operation
Derived quantities:
- words_total = ceil(cfg_num_elems/2), latched together with total = cfg_num_elems.

Counters:
- words_rx counts accepted stream beats.
- elems_tx counts wb_out_vld cycles.
- occ is the element occupancy, 0..CAP_ELEMS: occ_next = occ + 2·wb_weight_en − wb_out_vld.

Flow control:
- s_tready = (state==LOAD) & (words_rx < words_total) & (occ <= CAP_ELEMS-3).
- The extra slot of margin covers the one-cycle lag of wb_out_vld.

FSM states:
- IDLE: On start with cfg_num_elems ≠ 0, latch the config, clear the counters and err, and go to LOAD. On start with 0, pulse done and stay in IDLE.
- LOAD: Accept words. When the accepted beat makes words_rx == words_total, go to DRAIN.
- DRAIN: s_tready = 0. When wb_out_vld arrives with elems_tx == 2·words_total−1, go to DONE.
- DONE: Pulse done for one cycle, then go to IDLE.

Outputs:
- wb_out_en = busy.
- pe_wvalid = wb_out_vld & (elems_tx < total). The pad element of an odd job is drained from the buffer but not presented to the PE.
- pe_wlast = pe_wvalid & (elems_tx == total−1).

Framing errors set err (sticky) in both cases below; the job continues by count, not by tlast:
- s_tlast on a beat other than number words_total;
- no s_tlast on beat number words_total.

Other rules:
- start while busy is ignored.
- s_tvalid outside LOAD is ignored: no write and no error.

## Timing
Reset values:
- State = IDLE; all counters = 0.
- s_tready, wb_weight_en, wb_out_en, pe_wvalid, pe_wlast, busy, done, err = 0.
- wb_data and pe_wdata are combinational pass-throughs.

Latency:
- Accepted start → busy and s_tready high next cycle (if occ permits).
- A beat accepted at cycle t produces its first element on wb_out_vld at t+1.

Simultaneous events:
- A write and a drain in the same cycle give a net occ change of +1.
- start coincident with done is ignored.

Reset:
- nrst asserted mid-job returns everything to reset values immediately.
- Data already held in the buffer is abandoned.

Counter limits:
- occ never exceeds CAP_ELEMS and never underflows.
- Counters saturate at their widths; total ≤ 2^CNT_W−1.

## Test plan
- cfg_num_elems=6, 3 beats with tlast on the 3rd, tvalid held high:
  - 6 pe_wvalid pulses carrying the elements in order [15:0] then [31:16];
  - pe_wlast on the 6th pulse;
  - done exactly once; err=0.
- cfg_num_elems=5, 3 beats: 6 wb_out_vld cycles but only 5 pe_wvalid pulses, pe_wlast on the 5th, done pulse.
- cfg_num_elems=40 with the sink stalled by holding wb_out_vld low after the 1st beat: s_tready drops once occ reaches 12, and occ ≤ 14 at all times.
- cfg_num_elems=4 with tlast on beat 1: err=1, job still drains 4 elements, done pulses; the next start clears err.
- nrst pulsed low in the middle of LOAD: all outputs 0 in the same cycle; a subsequent start/job of 2 elements completes normally.
- start with cfg_num_elems=0: done pulses the next cycle, busy is never asserted, s_tready stays 0.
